// File: rtl/exu_seq_pkg.sv
// Shared types and defaults for the execution sequencer.
// State encoding, rd width and default cycle counts.
package exu_seq_pkg;

  localparam int RD_W               = 5;
  localparam int CLMUL_CYCLES_DEF   = 8;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_WAIT = 3'd1,
    S_LD_WB   = 3'd2,
    S_MC_RUN  = 3'd3,
    S_MC_WB   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag.
// Decrement saturates at zero so the count never wraps.
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/exu_sequencer.sv
// Multi-cycle load / CLMUL write-back sequencer.
// Optional load timeout: define EXU_MEM_TIMEOUT_EN.
module exu_sequencer
  import exu_seq_pkg::*;
#(
  parameter int CLMUL_CYCLES   = CLMUL_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_load,
  input  logic            issue_clmul,
  input  logic [RD_W-1:0] issue_rd,
  input  logic            kill,
  input  logic            mem_rvalid,
  output logic            stall,
  output logic            clmul_start,
  output logic            delayed_load,
  output logic            delayed_clmul,
  output logic [RD_W-1:0] delayed_rd,
  output logic            load_fault
);

  localparam logic [CNT_W-1:0] MC_LD =
    CNT_W'(CLMUL_CYCLES - 1);

  if (CLMUL_CYCLES < 1 || CLMUL_CYCLES > 255 ||
      CLMUL_CYCLES - 1 >= (1 << CNT_W) ||
      TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES - 1 >= (1 << CNT_W)) begin : g_bad_cfg
    $error("exu_sequencer: bad cycle/counter config");
  end

  seq_state_e       state, state_n;
  logic             acc;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             fault_set;

  assign acc = (state == S_IDLE) & ~kill &
               (issue_load | issue_clmul);

  seq_down_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      delayed_rd <= '0;
    end else begin
      state <= state_n;
      if (acc) delayed_rd <= issue_rd;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_load  = 1'b0;
    cnt_val   = MC_LD;
    cnt_dec   = 1'b0;
    fault_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (acc && issue_load) begin
          state_n = S_LD_WAIT;
`ifdef EXU_MEM_TIMEOUT_EN
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
        end else if (acc) begin
          state_n  = S_MC_RUN;
          cnt_load = 1'b1;
        end
      end
      S_LD_WAIT: begin
        if (kill) begin
          state_n = S_IDLE;
        end else if (mem_rvalid) begin
          state_n = S_LD_WB;
`ifdef EXU_MEM_TIMEOUT_EN
        end else if (cnt_zero) begin
          state_n   = S_IDLE;
          fault_set = 1'b1;
        end else begin
          cnt_dec = 1'b1;
`endif
        end
      end
      S_MC_RUN: begin
        if (kill) begin
          state_n = S_IDLE;
        end else if (cnt_zero) begin
          state_n = S_MC_WB;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef EXU_MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_fault <= 1'b0;
    end else if (fault_set) begin
      load_fault <= 1'b1;
    end
  end
`else
  assign load_fault = 1'b0;
`endif

  // Counter only ever counts down from MC_LD, so this marks the first run cycle
  assign clmul_start   = (state == S_MC_RUN) && (cnt == MC_LD);
  assign delayed_load  = (state == S_LD_WB);
  assign delayed_clmul = (state == S_MC_WB);
  assign stall         = (state != S_IDLE) | acc;

endmodule

// File: tb/tb_exu_sequencer.sv
// Directed self-checking bench for exu_sequencer.
// Timeout scenario is built when EXU_MEM_TIMEOUT_EN is defined.
module tb_exu_sequencer;
  import exu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       issue_load = 1'b0;
  logic       issue_clmul = 1'b0;
  logic [4:0] issue_rd = '0;
  logic       kill = 1'b0;
  logic       mem_rvalid = 1'b0;
  logic       stall, clmul_start, delayed_load, delayed_clmul;
  logic [4:0] delayed_rd;
  logic       load_fault;

  int checks = 0;
  int errors = 0;

  exu_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .issue_load    (issue_load),
    .issue_clmul   (issue_clmul),
    .issue_rd      (issue_rd),
    .kill          (kill),
    .mem_rvalid    (mem_rvalid),
    .stall         (stall),
    .clmul_start   (clmul_start),
    .delayed_load  (delayed_load),
    .delayed_clmul (delayed_clmul),
    .delayed_rd    (delayed_rd),
    .load_fault    (load_fault)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (stall !== 1'b0 || clmul_start !== 1'b0 ||
        delayed_load !== 1'b0 || delayed_clmul !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got st=%b cs=%b dl=%b dc=%b exp 0000",
               stall, clmul_start, delayed_load, delayed_clmul);
    end
    checks++;
    if (delayed_rd !== 5'd0 || load_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got rd=%0d lf=%b exp 0 0",
               delayed_rd, load_fault);
    end
    tick;
    rst = 1'b1;
    tick;
    checks++;
    if (dut.state !== S_IDLE || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got state=%0d stall=%b exp 0 0",
               dut.state, stall);
    end
  endtask

  task automatic test_load;
    int st, dl, dli, rdw;
    st = 0; dl = 0; dli = -1; rdw = -1;
    tick;
    issue_load = 1'b1; issue_rd = 5'd5; #1;
    for (int k = 0; k < 8; k++) begin
      if (stall) st++;
      if (delayed_load) begin dl++; dli = k; rdw = delayed_rd; end
      tick;
      issue_load = 1'b0;
      mem_rvalid = (k + 1 == 2);
      #1;
    end
    mem_rvalid = 1'b0;
    checks++;
    if (st !== 4) begin
      errors++;
      $display("FAIL load_stall: got %0d cycles exp 4", st);
    end
    checks++;
    if (dl !== 1 || dli !== 3) begin
      errors++;
      $display("FAIL load_wb: got n=%0d at %0d exp 1 at 3", dl, dli);
    end
    checks++;
    if (rdw !== 5) begin
      errors++;
      $display("FAIL load_rd: got %0d exp 5", rdw);
    end
  endtask

  task automatic test_clmul;
    int st, cs, csi, dc, dci, rdw, dl;
    st = 0; cs = 0; csi = -1; dc = 0; dci = -1; rdw = -1; dl = 0;
    tick;
    issue_clmul = 1'b1; issue_rd = 5'd7; #1;
    for (int k = 0; k < 14; k++) begin
      if (stall) st++;
      if (clmul_start) begin cs++; csi = k; end
      if (delayed_clmul) begin dc++; dci = k; rdw = delayed_rd; end
      if (delayed_load) dl++;
      tick;
      issue_clmul = 1'b0;
      issue_load  = (k + 1 == 3);
      issue_rd    = (k + 1 == 3) ? 5'd20 : 5'd0;
      #1;
    end
    issue_load = 1'b0;
    checks++;
    if (cs !== 1 || csi !== 1) begin
      errors++;
      $display("FAIL clmul_start: got n=%0d at %0d exp 1 at 1", cs, csi);
    end
    checks++;
    if (dc !== 1 || dci !== 9) begin
      errors++;
      $display("FAIL clmul_wb: got n=%0d at %0d exp 1 at 9", dc, dci);
    end
    checks++;
    if (st !== 10) begin
      errors++;
      $display("FAIL clmul_stall: got %0d exp 10", st);
    end
    checks++;
    if (rdw !== 7 || dl !== 0) begin
      errors++;
      $display("FAIL clmul_rd: got rd=%0d dl=%0d exp 7 0", rdw, dl);
    end
  endtask

  task automatic test_reset_mid_clmul;
    int dc, st;
    dc = 0; st = 0;
    tick;
    issue_clmul = 1'b1; issue_rd = 5'd11; #1;
    for (int k = 1; k <= 4; k++) begin
      tick;
      issue_clmul = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (dut.state !== S_IDLE || stall !== 1'b0 ||
        delayed_rd !== 5'd0 || delayed_clmul !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got state=%0d st=%b rd=%0d dc=%b exp 0 0 0 0",
               dut.state, stall, delayed_rd, delayed_clmul);
    end
    tick;
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (delayed_clmul) dc++;
      if (stall) st++;
    end
    checks++;
    if (dc !== 0 || st !== 0) begin
      errors++;
      $display("FAIL rst_mid_after: got dc=%0d st=%0d exp 0 0", dc, st);
    end
  endtask

  task automatic test_both_issue;
    int st, cs, dc, dl, dli, rdw;
    st = 0; cs = 0; dc = 0; dl = 0; dli = -1; rdw = -1;
    tick;
    issue_load = 1'b1; issue_clmul = 1'b1; issue_rd = 5'd3; #1;
    for (int k = 0; k < 14; k++) begin
      if (stall) st++;
      if (clmul_start) cs++;
      if (delayed_clmul) dc++;
      if (delayed_load) begin dl++; dli = k; rdw = delayed_rd; end
      tick;
      issue_load = 1'b0; issue_clmul = 1'b0;
      mem_rvalid = (k + 1 == 1);
      #1;
    end
    mem_rvalid = 1'b0;
    checks++;
    if (cs !== 0 || dc !== 0) begin
      errors++;
      $display("FAIL both_noclmul: got cs=%0d dc=%0d exp 0 0", cs, dc);
    end
    checks++;
    if (dl !== 1 || dli !== 2 || rdw !== 3 || st !== 3) begin
      errors++;
      $display("FAIL both_load: got n=%0d at %0d rd=%0d st=%0d exp 1 2 3 3",
               dl, dli, rdw, st);
    end
  endtask

  task automatic test_kill;
    int st, dl, dli, rdw;
    st = 0; dl = 0;
    tick;
    issue_load = 1'b1; issue_rd = 5'd9; #1;
    for (int k = 0; k < 7; k++) begin
      if (stall) st++;
      if (delayed_load) dl++;
      tick;
      issue_load = 1'b0;
      kill       = (k + 1 == 2);
      mem_rvalid = (k + 1 == 3);
      #1;
    end
    kill = 1'b0; mem_rvalid = 1'b0;
    checks++;
    if (dl !== 0 || st !== 3) begin
      errors++;
      $display("FAIL kill_ld: got dl=%0d st=%0d exp 0 3", dl, st);
    end
    kill = 1'b1; issue_load = 1'b1; issue_rd = 5'd30; #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL kill_idle_stall: got %b exp 0", stall);
    end
    tick;
    kill = 1'b0; issue_load = 1'b0; #1;
    checks++;
    if (stall !== 1'b0 || delayed_rd !== 5'd9) begin
      errors++;
      $display("FAIL kill_idle_acc: got st=%b rd=%0d exp 0 9",
               stall, delayed_rd);
    end
    st = 0; dl = 0; dli = -1; rdw = -1;
    tick;
    issue_load = 1'b1; issue_rd = 5'd12; #1;
    for (int k = 0; k < 6; k++) begin
      if (stall) st++;
      if (delayed_load) begin dl++; dli = k; rdw = delayed_rd; end
      tick;
      issue_load = 1'b0;
      mem_rvalid = (k + 1 == 1);
      #1;
    end
    mem_rvalid = 1'b0;
    checks++;
    if (dl !== 1 || dli !== 2 || rdw !== 12 || st !== 3) begin
      errors++;
      $display("FAIL kill_next: got n=%0d at %0d rd=%0d st=%0d exp 1 2 12 3",
               dl, dli, rdw, st);
    end
  endtask

`ifdef EXU_MEM_TIMEOUT_EN
  task automatic test_timeout;
    int st, dl, dli;
    st = 0; dl = 0;
    tick;
    issue_load = 1'b1; issue_rd = 5'd4; #1;
    for (int k = 0; k < 21; k++) begin
      if (stall) st++;
      if (delayed_load) dl++;
      tick;
      issue_load = 1'b0;
      #1;
    end
    checks++;
    if (st !== 17 || dl !== 0 || load_fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got st=%0d dl=%0d lf=%b exp 17 0 1",
               st, dl, load_fault);
    end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    st = 0; dl = 0; dli = -1;
    tick;
    issue_load = 1'b1; issue_rd = 5'd4; #1;
    for (int k = 0; k < 21; k++) begin
      if (stall) st++;
      if (delayed_load) begin dl++; dli = k; end
      tick;
      issue_load = 1'b0;
      mem_rvalid = (k + 1 == 16);
      #1;
    end
    mem_rvalid = 1'b0;
    checks++;
    if (st !== 18 || dl !== 1 || dli !== 17 || load_fault !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge: got st=%0d n=%0d at %0d lf=%b exp 18 1 17 0",
               st, dl, dli, load_fault);
    end
  endtask
`else
  task automatic test_timeout;
    int st, lf, dl;
    st = 0; lf = 0; dl = 0;
    tick;
    issue_load = 1'b1; issue_rd = 5'd4; #1;
    for (int k = 0; k < 40; k++) begin
      if (stall) st++;
      if (load_fault) lf++;
      if (delayed_load) dl++;
      tick;
      issue_load = 1'b0;
      #1;
    end
    checks++;
    if (st !== 40 || lf !== 0 || dl !== 0) begin
      errors++;
      $display("FAIL no_timeout: got st=%0d lf=%0d dl=%0d exp 40 0 0",
               st, lf, dl);
    end
    mem_rvalid = 1'b1;
    tick;
    mem_rvalid = 1'b0; #1;
    checks++;
    if (delayed_load !== 1'b1 || delayed_rd !== 5'd4) begin
      errors++;
      $display("FAIL no_timeout_wb: got dl=%b rd=%0d exp 1 4",
               delayed_load, delayed_rd);
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_load;
    test_clmul;
    test_reset_mid_clmul;
    test_both_issue;
    test_kill;
    test_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
